// File: rtl/frame_pkg.sv
// Shared definitions for the frame decoder: FSM state encoding and the default
// framing characters.
// Optional feature macro: FRAME_DECODER_CHECKSUM_EN (used by frame_decoder).
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    ESC  = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [7:0] START_CHAR_DEF = 8'h7E;
  localparam logic [7:0] END_CHAR_DEF   = 8'h7F;
  localparam logic [7:0] ESC_CHAR_DEF   = 8'h7D;

  // Width of a payload length/index for a given maximum payload size.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/frame_decoder_if.sv
// Byte-stream / frame-read bus between a producer-consumer and frame_decoder.
// Signals:
//   rx_data, rx_strobe  : received byte and its single-cycle strobe
//   frame_ready         : a complete frame is held
//   frame_len           : payload length of the held frame
//   rd_index, rd_byte   : combinational read port into the held frame
//   frame_ack           : consumer releases the held frame
//   err_overflow, err_dropped, err_checksum : single-cycle error pulses
// Modports: master (producer/consumer side), slave (decoder side).
// Optional feature macro: FRAME_DECODER_CHECKSUM_EN (affects only the decoder).
interface frame_decoder_if #(
  parameter int unsigned LW = 3
) ();

  logic [7:0]    rx_data;
  logic          rx_strobe;
  logic          frame_ready;
  logic [LW-1:0] frame_len;
  logic [LW-1:0] rd_index;
  logic [7:0]    rd_byte;
  logic          frame_ack;
  logic          err_overflow;
  logic          err_dropped;
  logic          err_checksum;

  modport master (
    output rx_data, rx_strobe, rd_index, frame_ack,
    input  frame_ready, frame_len, rd_byte, err_overflow, err_dropped, err_checksum
  );

  modport slave (
    input  rx_data, rx_strobe, rd_index, frame_ack,
    output frame_ready, frame_len, rd_byte, err_overflow, err_dropped, err_checksum
  );

endinterface

// File: rtl/frame_checksum.sv
// Running 8-bit modular sum of stored frame bytes with clear/add controls and a
// zero flag. Only instantiated when FRAME_DECODER_CHECKSUM_EN is defined.
// Ports:
//   clk_12MHz, reset : clock, synchronous active-high reset
//   i_clear          : restart the sum at zero (takes priority over i_add)
//   i_add, i_byte    : accumulate i_byte into the sum
//   o_zero           : current sum equals zero mod 256
module frame_checksum (
  input  logic       clk_12MHz,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_add,
  input  logic [7:0] i_byte,
  output logic       o_zero
);

  logic [7:0] r_sum;

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      r_sum <= 8'h00;
    end else if (i_clear) begin
      r_sum <= 8'h00;
    end else if (i_add) begin
      r_sum <= r_sum + i_byte;
    end
  end

  assign o_zero = (r_sum == 8'h00);

endmodule

// File: rtl/frame_decoder.sv
// Byte-stream frame decoder. Frames are START_CHAR, payload, END_CHAR; ESC_CHAR
// makes the following byte literal. A completed frame is held until frame_ack
// and may be read through the rd_index/rd_byte port.
// Optional feature macro: FRAME_DECODER_CHECKSUM_EN -- the last stored byte is
// a checksum; the 8-bit sum of all stored bytes must be zero to accept a frame.
// Ports:
//   clk_12MHz : sole clock, rising edge
//   reset     : synchronous, active-high
//   bus       : frame_decoder_if slave modport (byte input, frame read, errors)
module frame_decoder
  import frame_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 6,
  parameter logic [7:0]  START_CHAR = START_CHAR_DEF,
  parameter logic [7:0]  END_CHAR   = END_CHAR_DEF,
  parameter logic [7:0]  ESC_CHAR   = ESC_CHAR_DEF
) (
  input  logic           clk_12MHz,
  input  logic           reset,
  frame_decoder_if.slave bus
);

  localparam int unsigned LW = len_width(MAX_LEN);
`ifdef FRAME_DECODER_CHECKSUM_EN
  localparam int unsigned DEPTH = MAX_LEN + 1;  // payload plus checksum byte
`else
  localparam int unsigned DEPTH = MAX_LEN;
`endif
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e          r_state, w_state_next;
  logic [CW-1:0]   r_count, w_count_next;
  logic [LW-1:0]   r_len, w_len_next;
  logic            r_err_ovf, w_err_ovf;
  logic            r_err_drop, w_err_drop;
  logic            w_store_req;
  logic            w_store;
  logic [AW-1:0]   w_wr_addr;
  logic [AW-1:0]   w_rd_addr;
  logic [7:0]      r_buf [DEPTH];

`ifdef FRAME_DECODER_CHECKSUM_EN
  logic            r_err_cks, w_err_cks;
  logic            w_sum_clear;
  logic            w_sum_zero;
  logic [CW-1:0]   w_count_dec;

  assign w_count_dec = r_count - CW'(1);
`endif

  assign w_wr_addr = r_count[AW-1:0];
  assign w_rd_addr = AW'(bus.rd_index);

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_len_next   = r_len;
    w_err_ovf    = 1'b0;
    w_err_drop   = 1'b0;
    w_store_req  = 1'b0;
    w_store      = 1'b0;
`ifdef FRAME_DECODER_CHECKSUM_EN
    w_err_cks    = 1'b0;
    w_sum_clear  = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (bus.rx_strobe && (bus.rx_data == START_CHAR)) begin
          w_count_next = '0;
          w_state_next = RECV;
`ifdef FRAME_DECODER_CHECKSUM_EN
          w_sum_clear  = 1'b1;
`endif
        end
      end

      RECV: begin
        if (bus.rx_strobe) begin
          if (bus.rx_data == START_CHAR) begin
            // Resync: drop the partial frame silently.
            w_count_next = '0;
`ifdef FRAME_DECODER_CHECKSUM_EN
            w_sum_clear  = 1'b1;
`endif
          end else if (bus.rx_data == END_CHAR) begin
`ifdef FRAME_DECODER_CHECKSUM_EN
            // A lone checksum byte carries no payload.
            if (r_count <= CW'(1)) begin
              w_state_next = IDLE;
            end else if (!w_sum_zero) begin
              w_err_cks    = 1'b1;
              w_state_next = IDLE;
            end else begin
              w_len_next   = LW'(w_count_dec);
              w_state_next = HOLD;
            end
`else
            if (r_count == '0) begin
              w_state_next = IDLE;
            end else begin
              w_len_next   = LW'(r_count);
              w_state_next = HOLD;
            end
`endif
          end else if (bus.rx_data == ESC_CHAR) begin
            w_state_next = ESC;
          end else begin
            w_store_req = 1'b1;
          end
        end
      end

      ESC: begin
        if (bus.rx_strobe) begin
          w_store_req  = 1'b1;
          w_state_next = RECV;
        end
      end

      HOLD: begin
        if (bus.rx_strobe) begin
          w_err_drop = 1'b1;
        end
        if (bus.frame_ack) begin
          w_len_next   = '0;
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Shared store path for RECV data and escaped literals; a full buffer
    // aborts the frame and overrides whatever state was chosen above.
    if (w_store_req) begin
      if (r_count == CW'(DEPTH)) begin
        w_err_ovf    = 1'b1;
        w_count_next = '0;
        w_state_next = IDLE;
      end else begin
        w_store      = 1'b1;
        w_count_next = r_count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_len      <= '0;
      r_err_ovf  <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_len      <= w_len_next;
      r_err_ovf  <= w_err_ovf;
      r_err_drop <= w_err_drop;
    end
  end

  // Buffer contents are never reset; reads are masked outside a held frame.
  always_ff @(posedge clk_12MHz) begin
    if (!reset && w_store) begin
      r_buf[w_wr_addr] <= bus.rx_data;
    end
  end

`ifdef FRAME_DECODER_CHECKSUM_EN
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      r_err_cks <= 1'b0;
    end else begin
      r_err_cks <= w_err_cks;
    end
  end

  frame_checksum u_checksum (
    .clk_12MHz (clk_12MHz),
    .reset     (reset),
    .i_clear   (w_sum_clear),
    .i_add     (w_store),
    .i_byte    (bus.rx_data),
    .o_zero    (w_sum_zero)
  );

  assign bus.err_checksum = r_err_cks;
`else
  assign bus.err_checksum = 1'b0;
`endif

  assign bus.frame_ready  = (r_state == HOLD);
  assign bus.frame_len    = r_len;
  assign bus.err_overflow = r_err_ovf;
  assign bus.err_dropped  = r_err_drop;

  always_comb begin
    bus.rd_byte = 8'h00;
    if ((r_state == HOLD) && (bus.rd_index < r_len)) begin
      bus.rd_byte = r_buf[w_rd_addr];
    end
  end

endmodule

// File: tb/tb_frame_decoder.sv
// Self-checking bench for frame_decoder: reset checks, a table of directed
// vectors, hand-written multi-cycle sequences, and randomized traffic checked
// against a queue-based reference model. Honours FRAME_DECODER_CHECKSUM_EN.
module tb_frame_decoder;

  localparam int unsigned MAX_LEN = 6;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);
`ifdef FRAME_DECODER_CHECKSUM_EN
  localparam bit          CKS = 1'b1;
  localparam int unsigned CAP = MAX_LEN + 1;
`else
  localparam bit          CKS = 1'b0;
  localparam int unsigned CAP = MAX_LEN;
`endif

  logic clk_12MHz = 1'b0;
  logic reset     = 1'b1;

  frame_decoder_if #(.LW(LW)) bus ();

  frame_decoder #(.MAX_LEN(MAX_LEN)) dut (
    .clk_12MHz (clk_12MHz),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cycle(input logic [7:0] d, input logic s, input logic a,
                       input logic [LW-1:0] idx, input logic rst);
    bus.rx_data   = d;
    bus.rx_strobe = s;
    bus.frame_ack = a;
    bus.rd_index  = idx;
    reset         = rst;
    @(posedge clk_12MHz);
    #1;
    bus.rx_strobe = 1'b0;
    bus.frame_ack = 1'b0;
    reset         = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    cycle(d, 1'b1, 1'b0, '0, 1'b0);
  endtask

  // ---------------- reference model ----------------
  bit         m_in, m_esc, m_held;
  bit         e_ovf, e_drop, e_cks;
  logic [7:0] m_q[$];
  logic [7:0] m_hq[$];

  task automatic model_store(input logic [7:0] d);
    if (m_q.size() == CAP) begin
      e_ovf = 1'b1;
      m_in  = 1'b0;
      m_q.delete();
    end else begin
      m_q.push_back(d);
    end
  endtask

  task automatic model_step(input logic [7:0] d, input bit s, input bit a, input bit rst);
    int sum;
    e_ovf  = 1'b0;
    e_drop = 1'b0;
    e_cks  = 1'b0;
    if (rst) begin
      m_in = 1'b0; m_esc = 1'b0; m_held = 1'b0;
      m_q.delete(); m_hq.delete();
    end else if (m_held) begin
      if (s) e_drop = 1'b1;
      if (a) begin
        m_held = 1'b0;
        m_hq.delete();
      end
    end else if (s) begin
      if (!m_in) begin
        if (d == 8'h7E) begin
          m_in = 1'b1;
          m_esc = 1'b0;
          m_q.delete();
        end
      end else if (m_esc) begin
        m_esc = 1'b0;
        model_store(d);
      end else if (d == 8'h7E) begin
        m_q.delete();
      end else if (d == 8'h7F) begin
        m_in = 1'b0;
        sum  = 0;
        foreach (m_q[i]) sum += int'(m_q[i]);
        if (CKS) begin
          if (m_q.size() > 1) begin
            if ((sum % 256) != 0) begin
              e_cks = 1'b1;
            end else begin
              m_held = 1'b1;
              m_hq   = m_q[0:m_q.size()-2];
            end
          end
        end else if (m_q.size() > 0) begin
          m_held = 1'b1;
          m_hq   = m_q;
        end
      end else if (d == 8'h7D) begin
        m_esc = 1'b1;
      end else begin
        model_store(d);
      end
    end
  endtask

  task automatic compare_model(input logic [LW-1:0] idx);
    logic [7:0] exp_rd;
    exp_rd = (m_held && (int'(idx) < m_hq.size())) ? m_hq[idx] : 8'h00;
    check("rnd_ready", bus.frame_ready, m_held);
    check("rnd_len", bus.frame_len, m_held ? m_hq.size() : 0);
    check("rnd_rd_byte", bus.rd_byte, exp_rd);
    check("rnd_overflow", bus.err_overflow, e_ovf);
    check("rnd_dropped", bus.err_dropped, e_drop);
    check("rnd_checksum", bus.err_checksum, e_cks);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] d;
    bit         s;
    bit         a;
    bit         rdy;
    int         len;
    bit         ovf;
    bit         drp;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] exp041[4] = '{8'h01, 8'h02, 8'h03, 8'h00};
  logic [7:0] exp042[3] = '{8'h7F, 8'h7E, 8'h00};

  initial begin
    bus.rx_data   = 8'h00;
    bus.rx_strobe = 1'b0;
    bus.frame_ack = 1'b0;
    bus.rd_index  = '0;

    cycle(8'h00, 1'b0, 1'b0, '0, 1'b1);
    cycle(8'h7E, 1'b1, 1'b0, '0, 1'b1);
    check("reset_ready", bus.frame_ready, 1'b0);
    check("reset_len", bus.frame_len, 0);
    check("reset_overflow", bus.err_overflow, 1'b0);
    check("reset_dropped", bus.err_dropped, 1'b0);
    check("reset_checksum", bus.err_checksum, 1'b0);
    check("reset_rd_byte", bus.rd_byte, 8'h00);

`ifndef FRAME_DECODER_CHECKSUM_EN
    //            data   s  a  rdy len ovf drp
    tbl.push_back('{8'h41, 1, 0, 0, 0, 0, 0});  // ignored in IDLE
    tbl.push_back('{8'h7E, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h01, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h02, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h03, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h7F, 1, 0, 1, 3, 0, 0});
    tbl.push_back('{8'h00, 0, 0, 1, 3, 0, 0});
    tbl.push_back('{8'h55, 1, 0, 1, 3, 0, 1});  // dropped, still held
    tbl.push_back('{8'h55, 1, 1, 0, 0, 0, 1});  // drop and ack together
    tbl.push_back('{8'h00, 0, 1, 0, 0, 0, 0});  // ack outside HOLD
    tbl.push_back('{8'h7E, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h7F, 1, 0, 0, 0, 0, 0});  // empty frame
    tbl.push_back('{8'h7E, 1, 0, 0, 0, 0, 0});
    for (int i = 0; i < 6; i++) tbl.push_back('{8'(8'h11 + i), 1, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h17, 1, 0, 0, 0, 1, 0});  // 7th byte overflows
    tbl.push_back('{8'h7F, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h7E, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h01, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h7E, 1, 0, 0, 0, 0, 0});  // resync
    tbl.push_back('{8'h02, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h7F, 1, 0, 1, 1, 0, 0});
    tbl.push_back('{8'h00, 0, 1, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      cycle(tbl[i].d, tbl[i].s, tbl[i].a, '0, 1'b0);
      check($sformatf("tbl%0d_ready", i), bus.frame_ready, tbl[i].rdy);
      check($sformatf("tbl%0d_len", i), bus.frame_len, tbl[i].len);
      check($sformatf("tbl%0d_overflow", i), bus.err_overflow, tbl[i].ovf);
      check($sformatf("tbl%0d_dropped", i), bus.err_dropped, tbl[i].drp);
    end

    // Basic frame and masked read beyond frame_len.
    send(8'h7E); send(8'h01); send(8'h02); send(8'h03);
    check("f041_ready_before_end", bus.frame_ready, 1'b0);
    send(8'h7F);
    check("f041_ready", bus.frame_ready, 1'b1);
    check("f041_len", bus.frame_len, 3);
    for (int i = 0; i < 4; i++) begin
      bus.rd_index = LW'(i);
      #1;
      check($sformatf("f041_rd%0d", i), bus.rd_byte, exp041[i]);
    end
    cycle(8'h00, 1'b0, 1'b1, '0, 1'b0);
    check("f041_released", bus.frame_ready, 1'b0);

    // Escaped framing characters stored literally.
    send(8'h7E); send(8'h7D); send(8'h7F); send(8'h7D); send(8'h7E); send(8'h7F);
    check("f042_ready", bus.frame_ready, 1'b1);
    check("f042_len", bus.frame_len, 2);
    for (int i = 0; i < 3; i++) begin
      bus.rd_index = LW'(i);
      #1;
      check($sformatf("f042_rd%0d", i), bus.rd_byte, exp042[i]);
    end

    // Reset while HOLD.
    cycle(8'h00, 1'b0, 1'b0, '0, 1'b1);
    check("hold_reset_ready", bus.frame_ready, 1'b0);
    check("hold_reset_len", bus.frame_len, 0);

    // Reset mid-frame, strobe in the reset cycle ignored.
    send(8'h7E); send(8'h01); send(8'h02);
    cycle(8'h7E, 1'b1, 1'b0, '0, 1'b1);
    send(8'h05); send(8'h7F);
    check("f045_no_frame", bus.frame_ready, 1'b0);
    send(8'h7E); send(8'h09); send(8'h7F);
    check("f045_ready", bus.frame_ready, 1'b1);
    check("f045_len", bus.frame_len, 1);
    bus.rd_index = '0;
    #1;
    check("f045_rd0", bus.rd_byte, 8'h09);
    cycle(8'h00, 1'b0, 1'b1, '0, 1'b0);
`else
    send(8'h7E); send(8'h10); send(8'h20); send(8'hD0); send(8'h7F);
    check("f046_ready", bus.frame_ready, 1'b1);
    check("f046_len", bus.frame_len, 2);
    check("f046_cks", bus.err_checksum, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.rd_index = LW'(i);
      #1;
      check($sformatf("f046_rd%0d", i), bus.rd_byte, (i == 0) ? 8'h10 : (i == 1) ? 8'h20 : 8'h00);
    end
    cycle(8'h00, 1'b0, 1'b1, '0, 1'b0);
    check("f046_released", bus.frame_ready, 1'b0);
    send(8'h7E); send(8'h10); send(8'h20); send(8'hD1); send(8'h7F);
    check("f046_bad_cks_pulse", bus.err_checksum, 1'b1);
    check("f046_bad_ready", bus.frame_ready, 1'b0);
    cycle(8'h00, 1'b0, 1'b0, '0, 1'b0);
    check("f046_cks_single_cycle", bus.err_checksum, 1'b0);
    send(8'h7E); send(8'h00); send(8'h7F);
    check("f046_lone_byte_empty", bus.frame_ready, 1'b0);
`endif

    // Randomized traffic against the reference model.
    cycle(8'h00, 1'b0, 1'b0, '0, 1'b1);
    model_step(8'h00, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      logic [7:0]    d;
      logic [LW-1:0] idx;
      bit            s, a, rst;
      int            r;
      r = $urandom_range(0, 99);
      if (r < 15)      d = 8'h7E;
      else if (r < 27) d = 8'h7F;
      else if (r < 35) d = 8'h7D;
      else             d = 8'($urandom_range(0, 255));
      s   = ($urandom_range(0, 9) < 7);
      a   = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 199) == 0);
      idx = LW'($urandom_range(0, (1 << LW) - 1));
      cycle(d, s, a, idx, rst);
      model_step(d, s, a, rst);
      compare_model(idx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
